// File: rtl/router_pkt_reg.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_reg
// Brief    : 1x3 router datapath register stage. Holds the header, stalls one
//            byte across a FIFO-full event and checks the running XOR parity.
// Revision : 1.0  initial release
// ============================================================================
module router_pkt_reg #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          pkt_valid,
  input  logic [DW-1:0] data_in,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          rst_int_reg,
  output logic [DW-1:0] dout,
  output logic          parity_done,
  output logic          low_pkt_valid,
  output logic          err
);

  logic [DW-1:0] r_hdr;
  logic [DW-1:0] r_hold;
  logic [DW-1:0] r_int_par;
  logic [DW-1:0] r_pkt_par;
  logic [DW-1:0] r_dout;
  logic          r_parity_done;
  logic          r_low_pkt_valid;
  logic          r_err;

  logic          w_hdr_load;
  logic          w_par_byte;
  logic          w_pd_set;
  logic          w_int_par_acc;

  // Address 2'b11 is not a valid destination, so such a header is ignored.
  assign w_hdr_load    = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
  assign w_par_byte    = ld_state && !pkt_valid;
  assign w_pd_set      = (ld_state && !fifo_full && !pkt_valid) ||
                         (laf_state && r_low_pkt_valid && !r_parity_done);
  assign w_int_par_acc = ld_state && pkt_valid && !full_state;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_hdr <= '0;
    end else if (w_hdr_load) begin
      r_hdr <= data_in;
    end
  end

  // A byte arriving while the FIFO is full is parked in r_hold and replayed
  // from LOAD_AFTER_FULL.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_dout <= '0;
      r_hold <= '0;
    end else if (lfd_state) begin
      r_dout <= r_hdr;
    end else if (ld_state && !fifo_full) begin
      r_dout <= data_in;
    end else if (ld_state && fifo_full) begin
      r_hold <= data_in;
    end else if (laf_state) begin
      r_dout <= r_hold;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_int_par <= '0;
    end else if (detect_add) begin
      r_int_par <= '0;
    end else if (lfd_state) begin
      r_int_par <= r_int_par ^ r_hdr;
    end else if (w_int_par_acc) begin
      r_int_par <= r_int_par ^ data_in;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pkt_par <= '0;
    end else if (w_par_byte) begin
      r_pkt_par <= data_in;
    end else if (detect_add) begin
      r_pkt_par <= '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_low_pkt_valid <= 1'b0;
    end else if (w_par_byte) begin
      r_low_pkt_valid <= 1'b1;
    end else if (rst_int_reg) begin
      r_low_pkt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_parity_done <= 1'b0;
    end else if (w_pd_set) begin
      r_parity_done <= 1'b1;
    end else if (detect_add) begin
      r_parity_done <= 1'b0;
    end
  end

  // Compared continuously while parity_done is high, so err settles one
  // cycle after parity_done rises and then holds until the next header.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if (detect_add) begin
      r_err <= 1'b0;
    end else if (r_parity_done) begin
      r_err <= (r_int_par != r_pkt_par);
    end
  end

  assign dout          = r_dout;
  assign parity_done   = r_parity_done;
  assign low_pkt_valid = r_low_pkt_valid;
  assign err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_reg
// Brief    : Randomized packet-level self-checking bench for router_pkt_reg.
// Revision : 1.0  initial release
// ============================================================================
module tb_router_pkt_reg;

  localparam int DW = 8;

  logic          clock = 1'b0;
  logic          resetn;
  logic          pkt_valid;
  logic [DW-1:0] data_in;
  logic          fifo_full;
  logic          detect_add;
  logic          lfd_state;
  logic          ld_state;
  logic          laf_state;
  logic          full_state;
  logic          rst_int_reg;
  logic [DW-1:0] dout;
  logic          parity_done;
  logic          low_pkt_valid;
  logic          err;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] exp_dout;

  router_pkt_reg #(.DW(DW)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    pkt_valid   = 1'b0;
    data_in     = '0;
    fifo_full   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    for (int c = 0; c < 2; c++) begin
      pkt_valid   = 1'($urandom);
      data_in     = DW'($urandom);
      fifo_full   = 1'($urandom);
      detect_add  = 1'($urandom);
      lfd_state   = 1'($urandom);
      ld_state    = 1'($urandom);
      laf_state   = 1'($urandom);
      full_state  = 1'($urandom);
      rst_int_reg = 1'($urandom);
      tick();
    end
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_parity_done", 32'(parity_done), 32'd0);
    chk("rst_low_pkt_valid", 32'(low_pkt_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    idle_inputs();
    resetn   = 1'b1;
    exp_dout = '0;
  endtask

  // One packet as the control FSM would sequence it. Expected parity is the
  // XOR of header and payload; err must equal "sent parity != that XOR".
  task automatic send_packet(input bit corrupt, input bit full_par,
                             input bit retry_bad_addr, input int stall_pct);
    logic [DW-1:0] hdr;
    logic [DW-1:0] b;
    logic [DW-1:0] good_par;
    logic [DW-1:0] par;
    int            len;
    len      = $urandom_range(1, 6);
    hdr      = {6'(len), 2'($urandom_range(0, 2))};
    good_par = hdr;

    idle_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = hdr; tick();
    chk("decode_parity_done", 32'(parity_done), 32'd0);
    chk("decode_err", 32'(err), 32'd0);

    if (retry_bad_addr) begin
      data_in = {6'($urandom), 2'b11};
      tick();
    end

    idle_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; data_in = DW'($urandom); tick();
    exp_dout = hdr;
    chk("lfd_dout", 32'(dout), 32'(exp_dout));

    for (int i = 0; i < len; i++) begin
      b        = DW'($urandom);
      good_par = good_par ^ b;
      if ($urandom_range(0, 99) < stall_pct) begin
        idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; fifo_full = 1'b1; data_in = b; tick();
        chk("stall_dout", 32'(dout), 32'(exp_dout));
        idle_inputs(); full_state = 1'b1; pkt_valid = 1'b1; fifo_full = 1'b1; data_in = b; tick();
        chk("full_dout", 32'(dout), 32'(exp_dout));
        idle_inputs(); laf_state = 1'b1; pkt_valid = 1'b1; data_in = b; tick();
        exp_dout = b;
        chk("laf_dout", 32'(dout), 32'(exp_dout));
        chk("laf_parity_done", 32'(parity_done), 32'd0);
      end else begin
        idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = b; tick();
        exp_dout = b;
        chk("ld_dout", 32'(dout), 32'(exp_dout));
      end
    end

    par = corrupt ? (good_par ^ DW'(1 << $urandom_range(0, DW - 1))) : good_par;
    idle_inputs(); ld_state = 1'b1; data_in = par; fifo_full = full_par; tick();
    chk("par_low_pkt_valid", 32'(low_pkt_valid), 32'd1);
    if (full_par) begin
      chk("par_full_dout", 32'(dout), 32'(exp_dout));
      chk("par_full_parity_done", 32'(parity_done), 32'd0);
      idle_inputs(); laf_state = 1'b1; data_in = DW'($urandom); tick();
      exp_dout = par;
      chk("par_laf_dout", 32'(dout), 32'(exp_dout));
      chk("par_laf_parity_done", 32'(parity_done), 32'd1);
    end else begin
      exp_dout = par;
      chk("par_dout", 32'(dout), 32'(exp_dout));
      chk("par_parity_done", 32'(parity_done), 32'd1);
    end

    idle_inputs(); rst_int_reg = 1'b1; tick();
    chk("chk_low_pkt_valid", 32'(low_pkt_valid), 32'd0);
    chk("chk_err", 32'(err), 32'(corrupt));
    chk("chk_parity_done", 32'(parity_done), 32'd1);

    idle_inputs(); tick();
    chk("idle_err", 32'(err), 32'(corrupt));
    chk("idle_dout", 32'(dout), 32'(exp_dout));
  endtask

  initial begin
    logic [DW-1:0] b;
    idle_inputs();
    resetn = 1'b0;
    do_reset();

    send_packet(1'b0, 1'b0, 1'b0, 0);
    send_packet(1'b1, 1'b0, 1'b0, 0);
    send_packet(1'b0, 1'b0, 1'b0, 60);
    send_packet(1'b0, 1'b1, 1'b0, 0);
    send_packet(1'b1, 1'b1, 1'b1, 40);
    for (int k = 0; k < 30; k++) begin
      send_packet(1'($urandom), 1'($urandom), 1'($urandom), 30);
    end

    // Reset while err and parity_done are both set.
    send_packet(1'b1, 1'b0, 1'b0, 0);
    do_reset();

    // Reset in the middle of a payload, then confirm the header was cleared.
    idle_inputs(); detect_add = 1'b1; pkt_valid = 1'b1; data_in = 8'h0D; tick();
    idle_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; tick();
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = 8'h11; tick();
    chk("mid_ld_dout", 32'(dout), 32'h11);
    do_reset();
    b = DW'($urandom_range(1, 255));
    idle_inputs(); ld_state = 1'b1; pkt_valid = 1'b1; data_in = b; tick();
    chk("post_rst_ld_dout", 32'(dout), 32'(b));
    idle_inputs(); lfd_state = 1'b1; pkt_valid = 1'b1; tick();
    chk("post_rst_hdr", 32'(dout), 32'd0);

    send_packet(1'b0, 1'b0, 1'b1, 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
